// File: rtl/bellek_denetleyici.sv
// Burst initiator for one port of the dual-port memory: accepts read/write burst
// commands and sequences registered chip-select/write/output-enable bus cycles.
module bellek_denetleyici #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  cmd_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RCAP  = 2'd2,
        RWAIT = 2'd3
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [ADDR_WIDTH-1:0]   remaining;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // The bus is only ever driven during a registered write cycle, so the
    // memory (which drives only when we=0) can never collide with us.
    assign mem_data = (mem_cs && mem_we) ? mem_wdata : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            wr_ready  <= 1'b0;
            cmd_done  <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            cur_addr  <= '0;
            remaining <= '0;
        end else begin
            // Every bus cycle lasts exactly one clock unless re-issued below.
            cmd_done <= 1'b0;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_oe   <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr  <= cmd_addr;
                        remaining <= cmd_len;
                        cmd_ready <= 1'b0;
                        if (cmd_we) begin
                            wr_ready <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            mem_cs   <= 1'b1;
                            mem_oe   <= 1'b1;
                            mem_addr <= cmd_addr;
                            state    <= RCAP;
                        end
                    end
                end

                WRITE: begin
                    if (wr_valid) begin
                        mem_cs    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= cur_addr;
                        mem_wdata <= wr_data;
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == '0) begin
                            wr_ready  <= 1'b0;
                            cmd_ready <= 1'b1;
                            cmd_done  <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end

                RCAP: begin
                    // Memory latched the word on the negedge of the bus cycle.
                    rd_data  <= mem_data;
                    rd_valid <= 1'b1;
                    state    <= RWAIT;
                end

                RWAIT: begin
                    if (rd_ready) begin
                        rd_valid  <= 1'b0;
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == '0) begin
                            cmd_ready <= 1'b1;
                            cmd_done  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            mem_cs   <= 1'b1;
                            mem_oe   <= 1'b1;
                            mem_addr <= cur_addr + 1'b1;
                            state    <= RCAP;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bellek_denetleyici.md
BELLEK_DENETLEYICI -- requirements
Module: bellek_denetleyici

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-003 The block SHALL have port clk, input, 1, single clock for all logic.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1), the command handshake.
REQ-006 The block SHALL have port cmd_we, input, 1, 1 = write burst, 0 = read burst.
REQ-007 The block SHALL have port cmd_addr, input, ADDR_WIDTH, burst start address.
REQ-008 The block SHALL have port cmd_len, input, ADDR_WIDTH, burst length minus one (beats = cmd_len+1).
REQ-009 The block SHALL have ports wr_data (input, DATA_WIDTH), wr_valid (input, 1) and wr_ready (output, 1), the write-beat handshake.
REQ-010 The block SHALL have ports rd_data (output, DATA_WIDTH), rd_valid (output, 1) and rd_ready (input, 1), the read-beat handshake.
REQ-011 The block SHALL have port cmd_done, output, 1, one-cycle pulse at burst completion.
REQ-012 The block SHALL have port mem_addr, output, ADDR_WIDTH, memory port address.
REQ-013 The block SHALL have port mem_data, inout, DATA_WIDTH, bidirectional memory data bus.
REQ-014 The block SHALL have ports mem_cs, mem_we and mem_oe, each output, 1, memory chip select, write enable and output enable.

Function
REQ-015 The block SHALL act as initiator for one port of the team's dual-port memory: the memory writes on posedge when cs&we, latches read data on negedge when cs&!we, and drives data when cs&oe&!we.
REQ-016 All mem_* outputs and the mem_data drive value/enable SHALL be registered; mem_data SHALL be driven only while mem_cs&mem_we, and high-Z otherwise.
REQ-017 The FSM SHALL have states IDLE, WRITE, RCAP and RWAIT; cmd_ready SHALL be 1 only in IDLE.
REQ-018 On a cmd_valid&cmd_ready handshake, the block SHALL latch cmd_addr and cmd_len into cur_addr/remaining, then go to WRITE if cmd_we, else register a read bus cycle (cs=1, we=0, oe=1, mem_addr=cmd_addr) and go to RCAP.
REQ-019 In WRITE, wr_ready SHALL be 1; each wr_valid&wr_ready edge SHALL register mem_addr=cur_addr, mem_data=wr_data, cs=1, we=1 for exactly the next cycle, so the memory commits at the following posedge.
REQ-020 In WRITE, a cycle without wr_valid SHALL leave cs=0 (bubble); the burst SHALL NOT advance.
REQ-021 In RCAP, the block SHALL sample mem_data into rd_data at the next posedge, set rd_valid=1, drop cs/oe, and go to RWAIT; the read latency SHALL be exactly 1 cycle from bus cycle to sample.
REQ-022 In RWAIT, rd_valid and rd_data SHALL hold stable until rd_ready; on handshake with beats remaining, the block SHALL register the next read bus cycle and return to RCAP (2 cycles/beat minimum).
REQ-023 cur_addr SHALL increment by 1 per beat modulo 2^ADDR_WIDTH (wrap from max to 0); remaining SHALL decrement per beat.
REQ-024 After the last write beat is accepted, or after the last read handshake, the block SHALL return to IDLE and pulse cmd_done for exactly one cycle on the next cycle.
REQ-025 cmd_len=0 SHALL produce a single-beat burst; cmd_len=2^ADDR_WIDTH-1 SHALL cover every address once.
REQ-026 A new command SHALL be accepted in the IDLE cycle immediately after completion, while a final write bus cycle is still on the bus, with no bus conflict.
REQ-027 cmd_we, cmd_addr and cmd_len SHALL be ignored outside the handshake cycle.

Reset
REQ-028 On posedge clk with rst=1, the block SHALL enter IDLE with mem_cs=0, mem_we=0, mem_oe=0, mem_addr=0, mem_data high-Z, rd_valid=0, rd_data=0, cmd_done=0, wr_ready=0, and cmd_ready=1 from the next cycle.
REQ-029 Reset mid-burst SHALL abort the burst without a done pulse; a write bus cycle already registered before the reset edge SHALL complete at that edge, and no further beat SHALL be issued.

Verification
REQ-030 A write of addr=3, len=0, data=0xA5A5, followed by a read of addr=3, len=0, SHALL give rd_data=0xA5A5, with cmd_done pulsed after each command.
REQ-031 A write burst from addr=14, len=3, data 1,2,3,4 SHALL write addresses 14, 15, 0, 1 (wrap), and a read burst of the same SHALL return 1,2,3,4 in order.
REQ-032 A write burst with wr_valid gapped (1,0,0,1,...) SHALL give cs low in gap cycles, with all beats written correctly.
REQ-033 A read burst len=2 with rd_ready held low for 5 cycles on beat 1 SHALL keep rd_valid/rd_data stable, leave the bus idle, and issue no extra reads.
REQ-034 rst asserted after 2 of 4 write beats SHALL write only the first 2 addresses, give no cmd_done, and give IDLE with bus signals 0 and mem_data Z.
REQ-035 Back-to-back commands (write then read, issued immediately on cmd_ready) SHALL cause no X on mem_data and correct read-after-write data.
